// File: rtl/hadamard_normalize_pkg.sv
// Shared widths and helpers for the hadamard datapath stages.
// Every width is derived from (expWidth, sigWidth, low_expand) so all stages agree.
package hadamard_normalize_pkg;
  localparam int EXP_WIDTH_DEF  = 4;
  localparam int SIG_WIDTH_DEF  = 4;
  localparam int LOW_EXPAND_DEF = 2;

  // Sum width: sign, carry, hidden bit and headroom above the stored fraction and low bits.
  function automatic int sum_w(input int sig_w, input int low_e);
    return sig_w + 4 + low_e;
  endfunction

  function automatic int out_w(input int exp_w, input int sig_w);
    return 1 + exp_w + sig_w;
  endfunction

  // Position of 1.0 in the sum at the aligned exponent.
  function automatic int hb_pos(input int sig_w, input int low_e);
    return sig_w + low_e;
  endfunction

  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction
endpackage

// File: rtl/hadamard_normalize_if.sv
// Valid/ready bus between the hadamard adder and the normalizer, plus the packed-float output.
interface hadamard_normalize_if import hadamard_normalize_pkg::*; #(
  parameter int expWidth   = EXP_WIDTH_DEF,
  parameter int sigWidth   = SIG_WIDTH_DEF,
  parameter int low_expand = LOW_EXPAND_DEF
) ();
  localparam int SW = sum_w(sigWidth, low_expand);
  localparam int OW = out_w(expWidth, sigWidth);

  logic                in_valid;
  logic                in_ready;
  logic [SW-1:0]       sum_in;
  logic [expWidth-1:0] exp_in;
  logic                out_valid;
  logic                out_ready;
  logic [OW-1:0]       out_data;

  modport master (output in_valid, sum_in, exp_in, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, sum_in, exp_in, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/hadamard_lod.sv
// Combinational leading-one detect: {zero, position of the highest set bit}.
module hadamard_lod #(
  parameter int W  = 10,
  parameter int PW = $clog2(W)
) (
  input  logic [W-1:0] a,
  output logic [PW:0]  lod
);
  logic          zero;
  logic [PW-1:0] p;

  always_comb begin
    zero = 1'b1;
    p    = '0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) begin
        zero = 1'b0;
        p    = i[PW-1:0];
      end
    end
  end

  assign lod = {zero, p};
endmodule

// File: rtl/hadamard_normalize.sv
// Two-stage renormaliser: |sum| + leading-one detect, then shift, RNE round, saturate/flush.
module hadamard_normalize import hadamard_normalize_pkg::*; #(
  parameter int expWidth   = EXP_WIDTH_DEF,
  parameter int sigWidth   = SIG_WIDTH_DEF,
  parameter int low_expand = LOW_EXPAND_DEF
) (
  input logic clk,
  input logic rst,
  hadamard_normalize_if.slave io
);
  localparam int SW  = sum_w(sigWidth, low_expand);
  localparam int OW  = out_w(expWidth, sigWidth);
  localparam int HB  = hb_pos(sigWidth, low_expand);
  localparam int PW  = $clog2(SW);
  localparam int EW2 = expWidth + 2;
  localparam logic signed [EW2-1:0] E_MAX = EW2'((1 << expWidth) - 1);
  localparam logic signed [EW2-1:0] E_MIN = EW2'(1);

  typedef struct packed {
    logic                sign;
    logic                zero;
    logic [PW-1:0]       p;
    logic [SW-1:0]       mag;
    logic [expWidth-1:0] exp;
  } s1_t;

  logic [2:1] vld_pipe;
  s1_t        s1_q, s1_d;
  logic       s1_advance;
  logic [PW:0] lod;

  assign s1_advance  = !vld_pipe[2] || io.out_ready;
  assign io.in_ready = !vld_pipe[1] || s1_advance;
  assign io.out_valid = vld_pipe[2];

  // Stage 1: sign/magnitude split; -2^(SW-1) negates to itself, which is the correct unsigned magnitude.
  always_comb begin
    s1_d      = '0;
    s1_d.sign = io.sum_in[SW-1];
    s1_d.mag  = io.sum_in[SW-1] ? (~io.sum_in + 1'b1) : io.sum_in;
    s1_d.zero = lod[PW];
    s1_d.p    = lod[PW-1:0];
    s1_d.exp  = io.exp_in;
  end

  hadamard_lod #(.W(SW), .PW(PW)) u_lod (.a(s1_d.mag), .lod(lod));

  // Stage 2: shift the leading one just past the top so the fraction sits in the MSBs.
  logic [PW:0]             sh;
  logic [SW-1:0]           norm;
  logic [sigWidth-1:0]     frac, frac_r;
  logic                    g, s, inc, carry;
  logic signed [EW2-1:0]   e, e_r;
  logic [OW-1:0]           res;

  always_comb begin
    sh   = (PW+1)'(SW) - {1'b0, s1_q.p};
    norm = s1_q.mag << sh;
    frac = norm[SW-1 -: sigWidth];
    g    = norm[SW-1-sigWidth];
    s    = |norm[SW-2-sigWidth:0];
    inc  = g && (s || frac[0]);
    {carry, frac_r} = {1'b0, frac} + {{sigWidth{1'b0}}, inc};
    e    = $signed({2'b00, s1_q.exp}) + $signed({{(EW2-PW){1'b0}}, s1_q.p}) - $signed(EW2'(HB));
    e_r  = e + $signed({{(EW2-1){1'b0}}, carry});
    res  = '0;
    if (s1_q.zero || e_r < E_MIN) res = '0;
    else if (e_r > E_MAX)         res = {s1_q.sign, {expWidth{1'b1}}, {sigWidth{1'b1}}};
    else                          res = {s1_q.sign, e_r[expWidth-1:0], frac_r};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe    <= '0;
      s1_q        <= '0;
      io.out_data <= '0;
    end else begin
      if (io.in_ready) begin
        vld_pipe[1] <= io.in_valid;
        s1_q        <= s1_d;
      end
      if (s1_advance) begin
        vld_pipe[2] <= vld_pipe[1];
        io.out_data <= res;
      end
    end
  end
endmodule
